// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction fetch stage and its neighbours:
//   - NOP encoding driven on INST while nothing has been fetched
//   - fetch FSM state encoding (BOOT / RUN / FLUSH)
//   - default reset PC and buffer depth
//   - RV32I major opcodes, also used by decode
//   - buffer entry layout {pc, inst} and small PC helpers
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 2;

    // Major opcodes (inst[6:0]) shared with decode
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential next word; carry out of bit 31 is dropped so the PC wraps
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous DEPTH-entry FIFO of {pc, inst} between the memory response path
// and decode. The head entry is read straight out of the storage flops, so the
// consumer sees registered data with no extra pipeline stage.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   push_i/push_data_i  write an entry at the tail
//   pop_i          drop the head entry
//   flush_i        discard all entries (wins over push/pop)
//   full_o/empty_o occupancy flags
//   count_o        number of valid entries (0..DEPTH)
//   head_o         oldest entry (NOP/0 after reset)
// -----------------------------------------------------------------------------
module fetch_buffer
    import inst_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Qualify push/pop against occupancy; a push into a full buffer is dropped
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
    end

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset value makes the idle head read as NOP at PC 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '{pc: 32'h0000_0000, inst: NOP_INST};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/inst_fetch_checker.sv
// -----------------------------------------------------------------------------
// inst_fetch_checker
// Safety properties of the fetch stage, kept out of the datapath RTL.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   buf_push_i       fetch buffer push request
//   buf_full_i       fetch buffer full flag
//   imem_addr_lo_i   IMEM_ADDR[1:0]
// -----------------------------------------------------------------------------
module inst_fetch_checker (
    input logic       CLK,
    input logic       RST,
    input logic       buf_push_i,
    input logic       buf_full_i,
    input logic [1:0] imem_addr_lo_i
);

    // The credit rule must make a push into a full buffer impossible
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(buf_push_i && buf_full_i))
        else $fatal(1, "FAIL buf_overflow: push into full fetch buffer");

    // Fetch addresses are always word aligned
    a_addr_aligned: assert property (@(posedge CLK) disable iff (RST)
        imem_addr_lo_i == 2'b00)
        else $fatal(1, "FAIL addr_align: IMEM_ADDR[1:0]=%b required 00", imem_addr_lo_i);

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage: issues in-order word requests to instruction
// memory, buffers the returned words and hands {PC, INST} to decode.
// A redirect flushes the buffer; responses still owed by memory for the old
// path are drained and dropped in FLUSH before fetching resumes.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   IMEM_REQ/IMEM_ADDR   fetch request and word-aligned address
//   IMEM_GNT             request accepted this cycle
//   IMEM_RVALID/RDATA    in-order response word
//   REDIRECT/REDIRECT_PC new fetch target (bits [1:0] ignored)
//   INST/PC/INST_VALID   registered head of the instruction buffer
//   ID_READY             decode consumes INST when INST_VALID=1
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INST,
    output logic [31:0] PC,
    output logic        INST_VALID,
    input  logic        ID_READY
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;

    logic [CNT_W-1:0] buf_count_s;
    logic             buf_full_s;
    logic             buf_empty_s;
    logic             buf_push_s;
    logic             buf_pop_s;
    fetch_entry_t     buf_head_s;
    fetch_entry_t     push_entry_s;

    logic [CNT_W:0]   credit_used_s;
    logic             req_s;
    logic             gnt_s;
    logic             rsp_s;
    logic [31:0]      rsp_pc_s;

    // Request only in RUN while buffered + in-flight words leave room
    always_comb begin
        credit_used_s = {1'b0, buf_count_s} + {1'b0, outst_q};
        if (state_q == FS_RUN) begin
            req_s = (credit_used_s < CREDIT_MAX);
        end else begin
            req_s = 1'b0;
        end
    end

    // Grant/response bookkeeping; RVALID with nothing owed (e.g. right
    // after reset) is not ours and is ignored
    always_comb begin
        gnt_s   = req_s & IMEM_GNT;
        rsp_s   = IMEM_RVALID & (outst_q != CNT_W'(0));
        outst_d = outst_q;
        case ({gnt_s, rsp_s})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Responses return in order, so the oldest in-flight word sits
    // outstanding*4 bytes behind the fetch PC (modulo 2^32)
    always_comb begin
        rsp_pc_s     = fetch_pc_q - 32'({outst_q, 2'b00});
        push_entry_s = '{pc: rsp_pc_s, inst: IMEM_RDATA};
        buf_push_s   = rsp_s & (state_q == FS_RUN) & ~REDIRECT;
        buf_pop_s    = ~buf_empty_s & ID_READY & ~REDIRECT;
    end

    // Fetch PC: redirect target wins over sequential advance
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (REDIRECT) begin
            fetch_pc_d = word_align(REDIRECT_PC);
        end else if (gnt_s) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // FSM next state; FLUSH drains responses owed to the abandoned path
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (REDIRECT && (outst_d != CNT_W'(0))) begin
                    state_d = FS_FLUSH;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_FLUSH: begin
                if (outst_d == CNT_W'(0)) begin
                    state_d = FS_RUN;
                end else begin
                    state_d = FS_FLUSH;
                end
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    // State, fetch PC and credit registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FS_BOOT;
            fetch_pc_q <= word_align(RESET_PC);
            outst_q    <= CNT_W'(0);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (buf_push_s),
        .push_data_i (push_entry_s),
        .pop_i       (buf_pop_s),
        .flush_i     (REDIRECT),
        .full_o      (buf_full_s),
        .empty_o     (buf_empty_s),
        .count_o     (buf_count_s),
        .head_o      (buf_head_s)
    );

    assign IMEM_REQ   = req_s;
    assign IMEM_ADDR  = fetch_pc_q;
    assign INST       = buf_head_s.inst;
    assign PC         = buf_head_s.pc;
    assign INST_VALID = ~buf_empty_s;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed-plus-random bench for inst_fetch. A memory model answers grants in
// order after a random delay; a reference model tracks, at transaction level,
// which fetched words are still live, which are owed by memory, and which
// words decode must see next.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic [31:0] INST;
    logic [31:0] PC;
    logic        INST_VALID;
    logic        ID_READY = 1'b0;

    inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RST(RST), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .INST(INST), .PC(PC),
        .INST_VALID(INST_VALID), .ID_READY(ID_READY)
    );

    inst_fetch_checker u_chk (
        .CLK(CLK), .RST(RST),
        .buf_push_i(u_dut.buf_push_s), .buf_full_i(u_dut.buf_full_s),
        .imem_addr_lo_i(IMEM_ADDR[1:0])
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model state
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          dead;
    } mem_req_t;

    mem_req_t     mem_q[$];   // granted, response still owed by memory
    fetch_entry_t exp_q[$];   // words decode must see, oldest first
    logic [31:0]  m_pc;
    bit           m_boot;
    logic [31:0]  data_key = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int gnt_pct = 100;
    int rv_pct  = 100;
    int rdy_pct = 100;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The stage may ask for a word when out of boot, no abandoned responses
    // are still owed, and buffered + owed words leave a free slot
    function automatic bit model_req();
        bit dead = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].dead) dead = 1'b1;
        return !m_boot && !dead && ((exp_q.size() + mem_q.size()) < int'(DEPTH));
    endfunction

    // One clock: check outputs, drive inputs, advance the model at the edge
    task automatic tick(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0,
                        input bit force_all = 1'b0, input bit stale = 1'b0);
        bit       req_exp, vld_exp, gnt, rv, rdy;
        mem_req_t e;
        req_exp = model_req();
        vld_exp = (exp_q.size() != 0);
        chk1("imem_req", IMEM_REQ, req_exp);
        if (req_exp) chk32("imem_addr", IMEM_ADDR, m_pc);
        chk1("inst_valid", INST_VALID, vld_exp);
        if (vld_exp) begin
            chk32("pc", PC, exp_q[0].pc);
            chk32("inst", INST, exp_q[0].inst);
        end
        gnt = force_all || ($urandom_range(99) < gnt_pct);
        rv  = (mem_q.size() != 0) && (force_all || ($urandom_range(99) < rv_pct));
        rdy = force_all || ($urandom_range(99) < rdy_pct);
        IMEM_GNT    = gnt;
        IMEM_RVALID = rv || stale;
        IMEM_RDATA  = rv ? mem_q[0].data : $urandom();
        ID_READY    = rdy;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        @(posedge CLK);
        if (vld_exp && rdy && !redir) void'(exp_q.pop_front());
        if (rv) begin
            e = mem_q.pop_front();
            if (!e.dead && !redir) exp_q.push_back('{pc: e.addr, inst: e.data});
        end
        if (req_exp && gnt) begin
            mem_q.push_back('{addr: m_pc, data: m_pc ^ data_key, dead: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].dead = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end
        m_boot = 1'b0;
        @(negedge CLK);
        REDIRECT = 1'b0;
    endtask

    // Reset edge, reset-value checks, then release; optional stale RVALID
    // in the boot cycle that follows
    task automatic do_reset(input bit stale);
        RST = 1'b1;
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; REDIRECT = 1'b0; ID_READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        mem_q.delete();
        exp_q.delete();
        m_pc   = RPC;
        m_boot = 1'b1;
        chk1 ("rst_req",   IMEM_REQ,   1'b0);
        chk32("rst_addr",  IMEM_ADDR,  RPC);
        chk1 ("rst_valid", INST_VALID, 1'b0);
        chk32("rst_inst",  INST,       NOP_INST);
        chk32("rst_pc",    PC,         32'h0);
        RST = 1'b0;
        if (stale) tick(.stale(1'b1));
    endtask

    int          first_valid;
    int          found;
    bit          seen;
    logic [31:0] first_pc;
    logic [31:0] first_addr;

    initial begin
        @(negedge CLK);

        // A: streaming with immediate responses, RDATA equals address
        do_reset(1'b0);
        first_valid = -1;
        for (int c = 0; c < 20; c++) begin
            if (INST_VALID === 1'b1 && first_valid < 0) first_valid = c;
            tick();
        end
        chk32("a_first_valid_cycle", 32'(first_valid), 32'd3);

        // B: decode stalls, buffer fills, requests stop, then resume
        data_key = 32'hA5A5_0F0F;
        rdy_pct = 0;
        repeat (10) tick();
        chk1("b_req_dropped", IMEM_REQ, 1'b0);
        rdy_pct = 100;
        repeat (10) tick();

        // C: redirect with two requests outstanding
        rv_pct = 0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (mem_q.size() == 2) found = 1; else tick();
        end
        chk32("c_two_outstanding", 32'(found), 32'd1);
        tick(1'b1, 32'h0000_0102);
        chk1("c_flush_req_low", IMEM_REQ, 1'b0);
        rv_pct = 100;
        first_pc = 32'hFFFF_FFFF;
        first_addr = 32'hFFFF_FFFF;
        for (int c = 0; c < 20; c++) begin
            if (IMEM_REQ === 1'b1 && first_addr === 32'hFFFF_FFFF) first_addr = IMEM_ADDR;
            if (INST_VALID === 1'b1 && first_pc === 32'hFFFF_FFFF) first_pc = PC;
            tick();
        end
        chk32("c_first_req_addr", first_addr, 32'h0000_0100);
        chk32("c_first_pc", first_pc, 32'h0000_0100);

        // D: redirect, grant, response and ready all in one cycle
        rv_pct = 50;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            if (mem_q.size() != 0 && model_req()) found = 1; else tick();
        end
        chk32("d_precondition", 32'(found), 32'd1);
        tick(1'b1, 32'h0000_0200, 1'b1);
        chk1("d_valid_low", INST_VALID, 1'b0);
        rv_pct = 100;
        first_pc = 32'hFFFF_FFFF;
        for (int c = 0; c < 20; c++) begin
            if (INST_VALID === 1'b1 && first_pc === 32'hFFFF_FFFF) first_pc = PC;
            tick();
        end
        chk32("d_first_pc", first_pc, 32'h0000_0200);

        // E: fetch address wraps past the top of the address space
        tick(1'b1, 32'hFFFF_FFFD);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (IMEM_REQ === 1'b1 && IMEM_ADDR === 32'h0000_0000) seen = 1'b1;
            tick();
        end
        chk1("e_wrap_to_zero", seen, 1'b1);

        // F: reset with buffered words and requests in flight, stale RVALID
        rdy_pct = 0;
        rv_pct  = 100;
        repeat (4) tick();
        rv_pct = 0;
        repeat (3) tick();
        do_reset(1'b1);
        rdy_pct = 100;
        rv_pct  = 100;
        repeat (10) tick();

        // G: random traffic with occasional redirects
        for (int blk = 0; blk < 8; blk++) begin
            gnt_pct  = int'($urandom_range(100, 30));
            rv_pct   = int'($urandom_range(100, 20));
            rdy_pct  = int'($urandom_range(100, 20));
            data_key = $urandom();
            for (int c = 0; c < 50; c++) begin
                tick($urandom_range(99) < 6, $urandom());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage. Produces the 32-bit instruction word and its PC consumed by the decode stage.
- Issues in-order word requests to instruction memory over a request/grant + response-valid interface.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports PC redirect from branch/jump resolution, with a flush of in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory requests (power of two, ≥2).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- IMEM_REQ  output  1  fetch request valid.
- IMEM_ADDR  output  32  word-aligned fetch address; bits [1:0] always 0.
- IMEM_GNT  input  1  request accepted this cycle.
- IMEM_RVALID  input  1  response word valid this cycle.
- IMEM_RDATA  input  32  response word.
- REDIRECT  input  1  take new PC (branch/jump/jalr target).
- REDIRECT_PC  input  32  redirect target; bits [1:0] ignored.
- INST  output  32  instruction to decode.
- PC  output  32  address of INST.
- INST_VALID  output  1  INST/PC valid.
- ID_READY  input  1  decode consumes INST this cycle when INST_VALID=1.

Behaviour:
- Reset (RST=1 at edge) sets:
  - IMEM_REQ=0, IMEM_ADDR=RESET_PC, INST_VALID=0, INST=32'h0000_0013 (NOP), PC=0.
  - Buffer empty, outstanding count=0, FSM=BOOT.
  - Reset mid-operation abandons all in-flight responses. Any IMEM_RVALID in the first cycle after reset is ignored.
- FSM states:
  - BOOT: one cycle, no request; always → RUN.
  - RUN:
    - IMEM_REQ=1 when (buffer count + outstanding) < DEPTH.
    - On REQ&GNT: outstanding+1; fetch PC += 4 (32-bit wrap, 32'hFFFF_FFFC+4 → 0).
    - REDIRECT with outstanding (after this cycle's grant/response) > 0 → FLUSH; otherwise stays RUN.
  - FLUSH:
    - IMEM_REQ=0.
    - Each RVALID decrements outstanding and its data is discarded.
    - When outstanding reaches 0 → RUN at the next edge.
    - A REDIRECT during FLUSH overwrites the fetch PC and stays in FLUSH.
- Request handshake:
  - IMEM_ADDR = fetch PC and is stable while REQ=1 and GNT=0.
  - An ungranted request may be withdrawn on redirect; memory holds no commitment until GNT.
  - Responses are in order, exactly one per grant, earliest one cycle after the grant.
- Response handling:
  - In RUN, RVALID pushes {PC, RDATA} into the buffer and decrements outstanding.
  - The credit rule guarantees the buffer never overflows. A push while full is a fatal assertion.
- Output:
  - INST/PC/INST_VALID are the registered head of the buffer.
  - Minimum latency is grant at cycle N → RVALID at N+1 → INST_VALID at N+2.
  - A pop occurs when INST_VALID & ID_READY.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - INST/PC hold their values while INST_VALID=1 and ID_READY=0.
- Redirect (REDIRECT=1 at an edge):
  - Fetch PC ← {REDIRECT_PC[31:2], 2'b00}.
  - The buffer is flushed and INST_VALID=0 the next cycle.
  - Same-cycle RVALID is discarded but still decrements outstanding.
  - Same-cycle GNT is counted as outstanding and its response is discarded.
  - Same-cycle ID_READY pop has no further effect.
  - The first request to the target is issued the cycle after redirect, if outstanding=0.
- Width rules: the PC increment is a 32-bit unsigned add with carry dropped. The outstanding counter is wide enough for 0..DEPTH.

Decomposition:
- Shared package holds:
  - NOP encoding 32'h0000_0013.
  - FSM state encoding BOOT/RUN/FLUSH.
  - Default RESET_PC.
  - Opcode constants already shared with decode.
- Natural sub-module: fetch_buffer, a synchronous DEPTH-entry FIFO of {pc[31:0], inst[31:0]}.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, count, head.
- inst_fetch contains the FSM, fetch PC, credit counter and redirect logic.

Test Plan:
- Reset, GNT=1 always, RVALID one cycle after each grant, ID_READY=1, IMEM_RDATA=addr → addresses 0,4,8,… issued back-to-back. INST_VALID first rises 3 cycles after reset release (BOOT, grant, response) with PC=0, INST=0, then one instruction per cycle.
- ID_READY=0 for 10 cycles → after 2 words are buffered, IMEM_REQ drops. INST/PC hold 0/0. ID_READY=1 resumes in-order delivery with no gap or duplicate.
- Redirect to 32'h0000_0102 with 2 requests outstanding → FSM=FLUSH, REQ=0. Both responses are discarded. The next request has IMEM_ADDR=32'h0000_0100. The first delivered PC is 0x100 and no stale PC appears.
- REDIRECT, GNT, RVALID and ID_READY all asserted in the same cycle → the granted response is discarded. INST_VALID=0 next cycle and the first instruction delivered after it comes from the redirect target.
- Fetch PC at 32'hFFFF_FFFC → the next request address is 32'h0000_0000.
- RST asserted with a full buffer and 2 outstanding, stale RVALID in the cycle after reset → all outputs at reset values. The stale response is ignored and fetch restarts at RESET_PC.
